// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle.
// Master issues operations, slave is the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dataOut;
  logic             zero;

  modport master (
    output in_valid, dataA, dataB,
    output Signal, shamt, out_ready,
    input  in_ready, out_valid,
    input  dataOut, zero
  );

  modport slave (
    input  in_valid, dataA, dataB,
    input  Signal, shamt, out_ready,
    output in_ready, out_valid,
    output dataOut, zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// MIPS-style ALU with a bit-serial shifter (one bit per cycle).
// Define ALU_OVERFLOW_EN to add the registered overflow output.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic clk,
  input  logic rst,
  alu_multicycle_if.slave bus
`ifdef ALU_OVERFLOW_EN
  ,
  output logic overflow
`endif
);

  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic             rdy_q;
  logic             vld_q;
  logic [WIDTH-1:0] dout_q;
  logic             zero_q;
  logic [WIDTH-1:0] wrk_q;
  logic [SHW-1:0]   cnt_q;
  logic             left_q;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [5:0]       fn;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_sub;
  logic             is_shift;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] wrk_d;

  assign a  = bus.dataA;
  assign b  = bus.dataB;
  assign fn = bus.Signal;
  assign sh = bus.shamt;

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.dataOut   = dout_q;
  assign bus.zero      = zero_q;

  assign sum  = a + b;
  assign diff = a + ~b + WIDTH'(1);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) &&
                   (diff[WIDTH-1] != a[WIDTH-1]);
  assign is_shift = (fn == F_SLL) || (fn == F_SRL);

`ifdef ALU_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;
  logic ovf_add;

  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) &&
                   (sum[WIDTH-1] != a[WIDTH-1]);
  assign overflow = ovf_q;

  // Signed overflow flag, only meaningful for ADD/SUB
  always_comb begin
    ovf_d = 1'b0;
    if (fn == F_ADD) ovf_d = ovf_add;
    if (fn == F_SUB) ovf_d = ovf_sub;
  end
`endif

  // Single-cycle result; shifts here only cover shamt=0
  always_comb begin
    res_d = '0;
    case (fn)
      F_AND: res_d = a & b;
      F_OR:  res_d = a | b;
      F_ADD: res_d = sum;
      F_SUB: res_d = diff;
      F_SLT: res_d = {{(WIDTH-1){1'b0}},
                      diff[WIDTH-1] ^ ovf_sub};
      F_SLL: res_d = b;
      F_SRL: res_d = b;
      default: res_d = '0;
    endcase
  end

  // One-bit step of the serial shifter
  always_comb begin
    wrk_d = left_q ? (wrk_q << 1) : (wrk_q >> 1);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      dout_q  <= '0;
      zero_q  <= 1'b1;
      wrk_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            rdy_q <= 1'b0;
            if (is_shift && (sh != '0)) begin
              wrk_q   <= b;
              cnt_q   <= sh;
              left_q  <= (fn == F_SLL);
              state_q <= SHIFT;
            end else begin
              dout_q  <= res_d;
              zero_q  <= (res_d == '0);
              vld_q   <= 1'b1;
              state_q <= DONE;
`ifdef ALU_OVERFLOW_EN
              ovf_q   <= ovf_d;
`endif
            end
          end
        end
        SHIFT: begin
          wrk_q <= wrk_d;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            dout_q  <= wrk_d;
            zero_q  <= (wrk_d == '0);
            vld_q   <= 1'b1;
            state_q <= DONE;
`ifdef ALU_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal: 8, 16, 32).
REQ-002 Parameter SHW, default 5, shift-amount width; equals log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 dataA  input  WIDTH  operand A.
REQ-008 dataB  input  WIDTH  operand B.
REQ-009 Signal  input  6  MIPS funct code selecting operation.
REQ-010 shamt  input  SHW  shift amount, used only for shift ops.
REQ-011 out_valid  output  1  result held valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 dataOut  output  WIDTH  registered result.
REQ-014 zero  output  1  high when dataOut is all zeros; registered with dataOut.

Function
REQ-015 Request accepted on cycle with in_valid && in_ready; dataA, dataB, Signal, shamt captured then; later input changes ignored.
REQ-016 Funct codes: AND 100100 -> A&B; OR 100101 -> A|B; ADD 100000 -> A+B mod 2^WIDTH; SUB 100010 -> A-B mod 2^WIDTH; SLT 101010 -> 1 if A<B signed else 0; SLL 000000 -> B<<shamt; SRL 000010 -> B>>shamt logical.
REQ-017 SUB/SLT computed as A + ~B + 1; SLT result = sign(A-B) XOR signed overflow, zero-extended to WIDTH.
REQ-018 Unlisted funct code: result 0, zero=1, same timing as single-cycle ops.
REQ-019 FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-020 IDLE + accept of non-shift op: result written, next state DONE; out_valid high cycle after accept (latency 1).
REQ-021 IDLE + accept of shift op with shamt=0: result = B, next state DONE (latency 1).
REQ-022 IDLE + accept of shift op with shamt=N>0: working register loaded with B, counter loaded with N, next state SHIFT.
REQ-023 SHIFT: each cycle shift working register one bit (left for SLL, right zero-fill for SRL), decrement counter; on counter reaching 0 go DONE; out_valid rises N+1 cycles after accept.
REQ-024 DONE: out_valid=1, dataOut and zero stable; on out_ready=1 go IDLE same edge; no new request accepted in DONE cycle (in_ready=0).
REQ-025 out_ready ignored outside DONE; in_valid ignored outside IDLE.
REQ-026 dataOut/zero hold last completed result in IDLE; undefined intermediate values never visible while out_valid=0 is permitted but dataOut only updates on entry to DONE.

Reset
REQ-027 rst=1 at a clock edge: state IDLE, out_valid=0, dataOut=0, zero=1, counter=0; applies in any state incl. mid-SHIFT, aborting operation with no result delivered.
REQ-028 in_ready=1 on first cycle after rst deasserts.

Configuration
REQ-029 Macro ALU_OVERFLOW_EN: when defined, output port overflow (1 bit) added, registered with dataOut, set for ADD/SUB signed overflow, 0 for all other ops, reset to 0.
REQ-030 Without ALU_OVERFLOW_EN: no overflow port, no overflow logic; all other behaviour identical.

Verification (WIDTH=32)
REQ-031 Reset: hold rst 2 cycles in SHIFT with shamt=20 -> out_valid=0, dataOut=0, zero=1, in_ready=1 after release.
REQ-032 ADD A=0x7FFFFFFF, B=1 -> dataOut=0x80000000 one cycle after accept, zero=0, overflow=1 when ALU_OVERFLOW_EN defined.
REQ-033 SLT A=0xFFFFFFFF, B=1 -> dataOut=1; SLT A=1, B=0xFFFFFFFF -> dataOut=0; SUB A=5, B=5 -> dataOut=0, zero=1.
REQ-034 SRL B=0x80000000, shamt=31 -> out_valid rises exactly 32 cycles after accept, dataOut=0x00000001; SLL shamt=0 B=0x1234 -> 0x1234 at latency 1.
REQ-035 Backpressure: AND A=0xF0F0F0F0, B=0xFF00FF00, out_ready=0 for 5 cycles -> out_valid and dataOut=0xF000F000 stable, in_ready=0; in_valid with new op during stall ignored; out_ready=1 -> IDLE next cycle.
REQ-036 Funct 111111 -> dataOut=0, zero=1 at latency 1.
